// File: rtl/vga_pkg.sv
// Shared definitions for the bouncing-box animator: screen defaults,
// FSM state encoding and the per-axis move/bounce helper.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int V_VISIBLE_DEF = 480;
  localparam int BOX_SIZE_DEF  = 101;

  localparam int POS_W  = 11;
  localparam int CALC_W = 12;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_MOVE_X = 2'd1,
    ST_MOVE_Y = 2'd2,
    ST_COMMIT = 2'd3
  } vga_state_t;

  // Result of moving one axis by one step.
  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             bounce;
  } axis_move_t;

  // Move one axis, clamping at 0 / max_pos and reversing on contact.
  // The sum is formed in CALC_W bits so it can never wrap.
  function automatic axis_move_t axis_move(
    input logic [POS_W-1:0]  pos,
    input logic              dir,
    input logic [3:0]        step,
    input logic [CALC_W-1:0] max_pos
  );
    axis_move_t        r;
    logic [CALC_W-1:0] sum;
    sum      = {1'b0, pos} + {8'd0, step};
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    if (dir) begin
      if (sum >= max_pos) begin
        r.pos    = max_pos[POS_W-1:0];
        r.dir    = 1'b0;
        r.bounce = 1'b1;
      end else begin
        r.pos = sum[POS_W-1:0];
      end
    end else begin
      if ({1'b0, pos} <= {8'd0, step}) begin
        r.pos    = '0;
        r.dir    = 1'b1;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos - {7'd0, step};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_vs_edge_detect.sv
// Turns the active-low VS input into a one-cycle frame_tick on each
// falling edge. The sample register resets to 0 so a VS that is already
// low when reset releases is not mistaken for a new frame.
module vga_vs_edge_detect (
  input  logic vga_clk,
  input  logic reset,
  input  logic vs,
  output logic frame_tick
);

  logic vs_q;

  // Sample VS and flag the 1 -> 0 transition.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      vs_q       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vs;
      frame_tick <= vs_q & ~vs;
    end
  end

endmodule

// File: rtl/vga_box_animator.sv
// Moves a square around the visible area, bouncing off the edges.
// Each accepted frame runs WAIT -> MOVE_X -> MOVE_Y -> COMMIT; the new
// position and directions are staged and only become visible together
// at COMMIT, four edges after the frame_tick edge.
// frame_tick is a pure one-cycle pulse with no back-pressure: a tick
// that arrives while an update is in flight is simply dropped.
module vga_box_animator
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int BOX_SIZE  = BOX_SIZE_DEF,
  parameter int INIT_X    = 100,
  parameter int INIT_Y    = 100
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        VS,
  input  logic        enable,
  input  logic [3:0]  step,
  input  logic [3:0]  frame_div,
  output logic [10:0] box_x,
  output logic [10:0] box_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic        frame_tick,
  output logic        bounce_pulse,
  output logic [15:0] bounce_count,
  output vga_state_t  state_dbg
);

  localparam logic [CALC_W-1:0] XMAX   = CALC_W'(H_VISIBLE - BOX_SIZE);
  localparam logic [CALC_W-1:0] YMAX   = CALC_W'(V_VISIBLE - BOX_SIZE);
  localparam logic [POS_W-1:0]  INIT_XV = POS_W'(INIT_X);
  localparam logic [POS_W-1:0]  INIT_YV = POS_W'(INIT_Y);

  vga_state_t       state, state_nx;
  logic [3:0]       frame_cnt;
  logic [3:0]       step_q;
  logic [POS_W-1:0] nx_q, ny_q;
  logic             ndx_q, ndy_q;
  logic             bx_q, by_q;
  axis_move_t       mv_x, mv_y;
  logic [1:0]       bounce_add;
  logic [16:0]      bc_sum;
  logic             accept;

  vga_vs_edge_detect u_vs_edge (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .vs         (VS),
    .frame_tick (frame_tick)
  );

  assign state_dbg  = state;
  assign accept     = (state == ST_WAIT) && frame_tick && enable;
  assign mv_x       = axis_move(box_x, dir_x, step_q, XMAX);
  assign mv_y       = axis_move(box_y, dir_y, step_q, YMAX);
  assign bounce_add = {1'b0, bx_q} + {1'b0, by_q};
  assign bc_sum     = {1'b0, bounce_count} + {15'd0, bounce_add};

  // State register.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      state <= ST_WAIT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: leave WAIT only when the frame divider has run out.
  always_comb begin
    state_nx = state;
    case (state)
      ST_WAIT:   if (accept && (frame_cnt == frame_div)) state_nx = ST_MOVE_X;
      ST_MOVE_X: state_nx = ST_MOVE_Y;
      ST_MOVE_Y: state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_WAIT;
      default:   state_nx = ST_WAIT;
    endcase
  end

  // Datapath: frame divider, staged per-axis moves, atomic commit.
  // A frame_div lowered below the current count lets frame_cnt wrap
  // through 15 back to the new target; that is accepted behaviour.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      frame_cnt    <= 4'd0;
      step_q       <= 4'd0;
      nx_q         <= INIT_XV;
      ny_q         <= INIT_YV;
      ndx_q        <= 1'b1;
      ndy_q        <= 1'b1;
      bx_q         <= 1'b0;
      by_q         <= 1'b0;
      box_x        <= INIT_XV;
      box_y        <= INIT_YV;
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
      bounce_pulse <= 1'b0;
      bounce_count <= 16'd0;
    end else begin
      bounce_pulse <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (accept) begin
            if (frame_cnt == frame_div) begin
              frame_cnt <= 4'd0;
              step_q    <= step;
            end else begin
              frame_cnt <= frame_cnt + 4'd1;
            end
          end
        end
        ST_MOVE_X: begin
          nx_q  <= mv_x.pos;
          ndx_q <= mv_x.dir;
          bx_q  <= mv_x.bounce;
        end
        ST_MOVE_Y: begin
          ny_q  <= mv_y.pos;
          ndy_q <= mv_y.dir;
          by_q  <= mv_y.bounce;
        end
        ST_COMMIT: begin
          box_x        <= nx_q;
          box_y        <= ny_q;
          dir_x        <= ndx_q;
          dir_y        <= ndy_q;
          bounce_pulse <= bx_q | by_q;
          bounce_count <= bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_box_animator.sv
// Bench for vga_box_animator: three instances (default start, start near
// the right wall, start near the bottom-right corner) share one stimulus
// stream, so a single table of frames exercises plain moves, single and
// double bounces, enable=0, step=0 and the frame divider.
module tb_vga_box_animator;
  import vga_pkg::*;

  localparam int W = 40;

  // ---------------- clock / reset / DUTs ----------------
  logic        vga_clk = 1'b0;
  logic        reset;
  logic        VS;
  logic        enable;
  logic [3:0]  step;
  logic [3:0]  frame_div;
  logic [10:0] bx [3];
  logic [10:0] by [3];
  logic        dx [3];
  logic        dy [3];
  logic        ft [3];
  logic        bp [3];
  logic [15:0] bc [3];
  vga_state_t  st [3];

  always #5 vga_clk = ~vga_clk;

  vga_box_animator u_d0 (
    .vga_clk(vga_clk), .reset(reset), .VS(VS), .enable(enable), .step(step),
    .frame_div(frame_div), .box_x(bx[0]), .box_y(by[0]), .dir_x(dx[0]),
    .dir_y(dy[0]), .frame_tick(ft[0]), .bounce_pulse(bp[0]),
    .bounce_count(bc[0]), .state_dbg(st[0])
  );

  vga_box_animator #(.INIT_X(536)) u_d1 (
    .vga_clk(vga_clk), .reset(reset), .VS(VS), .enable(enable), .step(step),
    .frame_div(frame_div), .box_x(bx[1]), .box_y(by[1]), .dir_x(dx[1]),
    .dir_y(dy[1]), .frame_tick(ft[1]), .bounce_pulse(bp[1]),
    .bounce_count(bc[1]), .state_dbg(st[1])
  );

  vga_box_animator #(.INIT_X(537), .INIT_Y(377)) u_d2 (
    .vga_clk(vga_clk), .reset(reset), .VS(VS), .enable(enable), .step(step),
    .frame_div(frame_div), .box_x(bx[2]), .box_y(by[2]), .dir_x(dx[2]),
    .dir_y(dy[2]), .frame_tick(ft[2]), .bounce_pulse(bp[2]),
    .bounce_count(bc[2]), .state_dbg(st[2])
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic             en;
    logic [3:0]       step;
    logic [3:0]       div;
    logic [2:0][10:0] x;
    logic [2:0][10:0] y;
    logic [2:0]       dx;
    logic [2:0]       dy;
    logic [2:0][15:0] cnt;
    logic [2:0][1:0]  pulses;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  function automatic logic [W-1:0] pack_out(input int k);
    return {bx[k], by[k], dx[k], dy[k], bc[k]};
  endfunction

  function automatic logic [W-1:0] pack_exp(input logic [10:0] x, input logic [10:0] y,
                                            input logic ddx, input logic ddy, input logic [15:0] c);
    return {x, y, ddx, ddy, c};
  endfunction

  // ---------------- driver ----------------
  // One VS fall per call; samples every cycle #1 after the edge.
  // c==0 is the first sample after E0, c==4 the first after E4.
  task automatic apply_vec(input int i, input bit timed);
    int pulse_cnt[3];
    for (int k = 0; k < 3; k++) pulse_cnt[k] = 0;
    @(negedge vga_clk);
    enable    = vecs[i].en;
    step      = vecs[i].step;
    frame_div = vecs[i].div;
    for (int k = 0; k < 3; k++)
      exp_q.push_back(pack_exp(vecs[i].x[k], vecs[i].y[k], vecs[i].dx[k],
                               vecs[i].dy[k], vecs[i].cnt[k]));
    VS = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge vga_clk); #1;
      for (int k = 0; k < 3; k++) if (bp[k]) pulse_cnt[k]++;
      if (timed) begin
        case (c)
          0: chk("tick_at_e0", W'(ft[0]), W'(1));
          1: chk("tick_one_cycle", W'(ft[0]), W'(0));
          3: chk("x_before_e4", W'(bx[0]), W'(100));
          4: begin
            chk("x_at_e4", W'(bx[0]), W'(104));
            chk("y_at_e4", W'(by[0]), W'(104));
            chk("d1_pulse_at_e4", W'(bp[1]), W'(1));
          end
          default: ;
        endcase
      end
      if (c == 3) VS = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("vec%0d_dut%0d_out", i, k), pack_out(k), exp_q.pop_front());
      chk($sformatf("vec%0d_dut%0d_pulses", i, k), W'(pulse_cnt[k]), W'(vecs[i].pulses[k]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_d0"}, pack_out(0), pack_exp(11'd100, 11'd100, 1'b1, 1'b1, 16'd0));
    chk({tag, "_d1"}, pack_out(1), pack_exp(11'd536, 11'd100, 1'b1, 1'b1, 16'd0));
    chk({tag, "_d2"}, pack_out(2), pack_exp(11'd537, 11'd377, 1'b1, 1'b1, 16'd0));
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_tick"}, W'(ft[k]), W'(0));
      chk({tag, "_pulse"}, W'(bp[k]), W'(0));
      chk({tag, "_state"}, W'(st[k]), W'(ST_WAIT));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int tick_seen;
    // Expected values per frame, instance order {d2, d1, d0}.
    vecs[0] = '{en:1'b1, step:4'd4, div:4'd0,
                x:{11'd539, 11'd539, 11'd104}, y:{11'd379, 11'd104, 11'd104},
                dx:3'b001, dy:3'b011, cnt:{16'd2, 16'd1, 16'd0}, pulses:{2'd1, 2'd1, 2'd0}};
    vecs[1] = '{en:1'b1, step:4'd4, div:4'd0,
                x:{11'd535, 11'd535, 11'd108}, y:{11'd375, 11'd108, 11'd108},
                dx:3'b001, dy:3'b011, cnt:{16'd2, 16'd1, 16'd0}, pulses:{2'd0, 2'd0, 2'd0}};
    vecs[2] = vecs[1]; vecs[2].en = 1'b0;
    vecs[3] = vecs[2];
    vecs[4] = vecs[1]; vecs[4].step = 4'd0;
    vecs[5] = vecs[1]; vecs[5].div = 4'd2;
    vecs[6] = vecs[5];
    vecs[7] = '{en:1'b1, step:4'd4, div:4'd2,
                x:{11'd531, 11'd531, 11'd112}, y:{11'd371, 11'd112, 11'd112},
                dx:3'b001, dy:3'b011, cnt:{16'd2, 16'd1, 16'd0}, pulses:{2'd0, 2'd0, 2'd0}};
    vecs[8] = '{en:1'b1, step:4'd15, div:4'd0,
                x:{11'd516, 11'd516, 11'd127}, y:{11'd356, 11'd127, 11'd127},
                dx:3'b001, dy:3'b011, cnt:{16'd2, 16'd1, 16'd0}, pulses:{2'd0, 2'd0, 2'd0}};

    reset = 1'b0; VS = 1'b1; enable = 1'b0; step = 4'd0; frame_div = 4'd0;
    repeat (3) @(negedge vga_clk);
    check_reset_values("reset");
    reset = 1'b1;
    repeat (3) @(negedge vga_clk);

    for (int i = 0; i < 9; i++) apply_vec(i, i == 0);

    // Reset asserted while the FSM sits in MOVE_Y: nothing may commit.
    @(negedge vga_clk);
    enable = 1'b1; step = 4'd4; frame_div = 4'd0;
    VS = 1'b0;
    repeat (3) begin @(posedge vga_clk); #1; end
    chk("state_move_y", W'(st[0]), W'(ST_MOVE_Y));
    reset = 1'b0;
    #1;
    check_reset_values("mid_reset");

    // Release with VS still low: no frame_tick and no movement.
    repeat (3) @(negedge vga_clk);
    reset = 1'b1;
    tick_seen = 0;
    repeat (8) begin
      @(posedge vga_clk); #1;
      for (int k = 0; k < 3; k++) if (ft[k]) tick_seen++;
    end
    chk("no_tick_after_release", W'(tick_seen), W'(0));
    chk("held_after_release", pack_out(0), pack_exp(11'd100, 11'd100, 1'b1, 1'b1, 16'd0));

    // A genuine rise and fall afterwards animates normally again.
    @(negedge vga_clk);
    VS = 1'b1;
    repeat (3) @(negedge vga_clk);
    apply_vec(0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard time bound so a broken DUT can never hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_box_animator.md
VGA_BOX_ANIMATOR -- requirements
Module: vga_box_animator

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-003 SHALL have parameter BOX_SIZE, default 101, square edge length in pixels.
REQ-004 SHALL have parameter INIT_X, default 100, reset value of box_x.
REQ-005 SHALL have parameter INIT_Y, default 100, reset value of box_y.
REQ-006 SHALL have port vga_clk  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port VS  in  1  active-low vertical sync from the sync generator, vga_clk domain.
REQ-009 SHALL have port enable  in  1  1 = animate, 0 = freeze.
REQ-010 SHALL have port step  in  4  pixels moved per axis per update.
REQ-011 SHALL have port frame_div  in  4  update once every frame_div+1 frames.
REQ-012 SHALL have port box_x  out  11  top-left column of square, consumed by the pixel colour stage.
REQ-013 SHALL have port box_y  out  11  top-left row of square.
REQ-014 SHALL have port dir_x  out  1  1 = moving right (increasing x).
REQ-015 SHALL have port dir_y  out  1  1 = moving down (increasing y).
REQ-016 SHALL have port frame_tick  out  1  one-cycle pulse per VS falling edge.
REQ-017 SHALL have port bounce_pulse  out  1  one-cycle pulse when a commit included any wall bounce.
REQ-018 SHALL have port bounce_count  out  16  saturating count of axis bounces.

Function
REQ-019 SHALL register VS each cycle; frame_tick SHALL rise at edge E0 where VS is sampled 0 and the previous sample was 1, high for exactly one cycle.
REQ-020 SHALL implement FSM WAIT -> MOVE_X -> MOVE_Y -> COMMIT -> WAIT, one cycle per non-WAIT state.
REQ-021 In WAIT with frame_tick=1 and enable=1: if frame_cnt==frame_div, SHALL clear frame_cnt, latch step, go to MOVE_X; else increment frame_cnt, stay WAIT.
REQ-022 With enable=0, SHALL ignore frame_tick, hold frame_cnt and all outputs except frame_tick.
REQ-023 XMAX = H_VISIBLE-BOX_SIZE (539), YMAX = V_VISIBLE-BOX_SIZE (379); arithmetic SHALL use 12 bits, no wrap.
REQ-024 MOVE_X, dir_x=1: if box_x+step >= XMAX then nx=XMAX, dir_x flips, bounce flagged; else nx=box_x+step.
REQ-025 MOVE_X, dir_x=0: if box_x <= step then nx=0, dir_x flips, bounce flagged; else nx=box_x-step.
REQ-026 MOVE_Y SHALL apply REQ-024/025 identically to box_y, dir_y, YMAX.
REQ-027 COMMIT SHALL update box_x and box_y on the same edge (E4 after E0); no intermediate value visible.
REQ-028 COMMIT SHALL add number of bounced axes (0/1/2) to bounce_count, saturating at 65535; bounce_pulse high one cycle if ≥1.
REQ-029 step=0 SHALL produce no movement and no bounce unless position already on a wall in travel direction.
REQ-030 frame_tick arriving outside WAIT SHALL be ignored.

Reset
REQ-031 reset low SHALL immediately force: box_x=INIT_X, box_y=INIT_Y, dir_x=1, dir_y=1, frame_tick=0, bounce_pulse=0, bounce_count=0, frame_cnt=0, FSM=WAIT, VS sample register=0.
REQ-032 Reset mid-update SHALL abort without commit; VS low at release SHALL NOT produce frame_tick.

Structure
REQ-033 Shared package vga_pkg SHALL hold H_VISIBLE, V_VISIBLE, BOX_SIZE defaults and FSM state encoding.
REQ-034 Single sub-module vga_vs_edge_detect SHALL implement REQ-019.

Verification
REQ-035 Defaults, step=4, frame_div=0, enable=1, one VS fall -> frame_tick at E0, box_x=box_y=104 at E4.
REQ-036 frame_div=2, three VS falls -> position unchanged after 1st/2nd, 104/104 after 3rd.
REQ-037 INIT_X=536, step=4, one frame -> box_x=539, dir_x=0, bounce_count=1, bounce_pulse one cycle; next frame box_x=535.
REQ-038 INIT_X=537, INIT_Y=377, step=4 -> box_x=539, box_y=379, both dirs 0, bounce_count=2, single bounce_pulse.
REQ-039 enable=0 over two VS falls -> outputs held; reset asserted in MOVE_Y -> outputs at reset values, no commit.
REQ-040 Reset released with VS=0, then VS held low -> no frame_tick until VS rises and falls again.
